// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and sizing helpers for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } fetch_state_t;

    function automatic int unsigned fetch_bytes(input int unsigned instr_w,
                                                input int unsigned data_w);
        return instr_w / data_w;
    endfunction

    // Index registers need at least one bit even for single-word instructions.
    function automatic int unsigned idx_bits(input int unsigned bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

    localparam int unsigned BYTES = fetch_bytes(32, 8);
    localparam int unsigned IDX_W = idx_bits(BYTES);
    localparam int unsigned CNT_W = $clog2(2 + 1);

endpackage

// File: rtl/instr_fetch_unit_latency_counter.sv
// Wait-phase counter for the fetch unit: clears on issue, counts during wait,
// flags the cycle in which RAM read data is valid.
module fetch_latency_counter #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CNT_W   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CNT_W'(LATENCY - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetcher: packs INSTR_W/DATA_W sequential RAM reads little-endian.
// Optional macro FETCH_ALIGN_CHECK_EN rejects pc_in not aligned to the instruction size.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned INSTR_W     = 32,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned RAM_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               flush,
    input  logic [PC_W-1:0]    pc_in,
    output logic               busy,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic               fetch_err,
    output logic               mem_rden,
    output logic               mem_wren,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]  mem_q
);

    localparam int unsigned NBYTES   = fetch_bytes(INSTR_W, DATA_W);
    localparam int unsigned IDX_BITS = idx_bits(NBYTES);
    localparam int unsigned CNT_BITS = $clog2(RAM_LATENCY + 1);

    fetch_state_t        state;
    logic [ADDR_W-1:0]   base;
    logic [IDX_BITS-1:0] idx;
    logic [IDX_BITS-1:0] next_idx;
    logic                last_byte;
    logic                data_ready;
    logic                reject;

    assign mem_wren  = 1'b0;
    assign next_idx  = idx + 1'b1;
    assign last_byte = (idx == IDX_BITS'(NBYTES - 1));

    always_comb begin
        reject = |(pc_in >> ADDR_W);
`ifdef FETCH_ALIGN_CHECK_EN
        reject = reject | (|(pc_in & PC_W'(NBYTES - 1)));
`endif
    end

    fetch_latency_counter #(
        .LATENCY (RAM_LATENCY),
        .CNT_W   (CNT_BITS)
    ) u_lat_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state == S_ISSUE),
        .en  (state == S_WAIT),
        .tc  (data_ready)
    );

    // Outputs are registered on the transition into the state that owns them,
    // so mem_rden/mem_addr are valid throughout ISSUE and the pulses line up with DONE/ERR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            mem_rden    <= 1'b0;
            mem_addr    <= '0;
            instr       <= '0;
            base        <= '0;
            idx         <= '0;
        end else begin
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            mem_rden    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        busy <= 1'b1;
                        if (reject) begin
                            state     <= S_ERR;
                            fetch_err <= 1'b1;
                        end else begin
                            state    <= S_ISSUE;
                            base     <= pc_in[ADDR_W-1:0];
                            idx      <= '0;
                            mem_rden <= 1'b1;
                            mem_addr <= pc_in[ADDR_W-1:0];
                        end
                    end
                end
                S_ISSUE: begin
                    if (flush) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (data_ready) begin
                        instr[int'(idx)*DATA_W +: DATA_W] <= mem_q;
                        if (last_byte) begin
                            state       <= S_DONE;
                            instr_valid <= 1'b1;
                        end else begin
                            state    <= S_ISSUE;
                            idx      <= next_idx;
                            mem_rden <= 1'b1;
                            mem_addr <= base + ADDR_W'(next_idx);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                S_ERR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench: three fetch units (RAM latency 2, 1, 4) against a shared behavioural RAM.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start = '0;
    logic        flush = 1'b0;
    logic [31:0] pc_in = '0;
    logic [2:0]  busy, instr_valid, fetch_err, mem_rden, mem_wren;
    logic [31:0] instr [3];
    logic [15:0] mem_addr [3];
    logic [7:0]  mem_q [3];

    logic [7:0]  ram [0:65535];

    int          n_checks = 0;
    int          n_errors = 0;

    int          cyc = 0;
    int          rd_cnt [3];
    int          v_cnt [3];
    int          v_cyc [3];
    int          e_cnt [3];
    int          e_cyc [3];
    logic [15:0] addr_log [3][8];
    logic        clr_log = 1'b0;
    logic [31:0] exp_instr;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        logic [15:0] pipe_a [4];
        logic [3:0]  pipe_v = '0;

        always @(posedge clk) begin
            pipe_a[0] <= mem_addr[g];
            pipe_v[0] <= mem_rden[g];
            for (int i = 1; i < 4; i++) begin
                pipe_a[i] <= pipe_a[i-1];
                pipe_v[i] <= pipe_v[i-1];
            end
        end

        assign mem_q[g] = pipe_v[LAT-1] ? ram[pipe_a[LAT-1]] : 8'hEE;

        instr_fetch_unit #(
            .ADDR_W      (16),
            .DATA_W      (8),
            .INSTR_W     (32),
            .PC_W        (32),
            .RAM_LATENCY (LAT)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start[g]),
            .flush       (flush),
            .pc_in       (pc_in),
            .busy        (busy[g]),
            .instr_valid (instr_valid[g]),
            .instr       (instr[g]),
            .fetch_err   (fetch_err[g]),
            .mem_rden    (mem_rden[g]),
            .mem_wren    (mem_wren[g]),
            .mem_addr    (mem_addr[g]),
            .mem_q       (mem_q[g])
        );
    end

    // cyc numbers cycles from the edge that samples start (cycle 1 follows it)
    always @(negedge clk) begin
        if (clr_log) begin
            cyc = 0;
            for (int i = 0; i < 3; i++) begin
                rd_cnt[i] = 0; v_cnt[i] = 0; v_cyc[i] = 0; e_cnt[i] = 0; e_cyc[i] = 0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (mem_rden[i]) begin
                    if (rd_cnt[i] < 8) addr_log[i][rd_cnt[i]] = mem_addr[i];
                    rd_cnt[i]++;
                end
                if (instr_valid[i]) begin v_cnt[i]++; v_cyc[i] = cyc; end
                if (fetch_err[i]) begin e_cnt[i]++; e_cyc[i] = cyc; end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [2:0] mask, input logic [31:0] pc);
        @(posedge clk); #1;
        start   = mask;
        pc_in   = pc;
        clr_log = 1'b1;
        @(posedge clk); #1;
        start   = '0;
        clr_log = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
        ram[16'h0010] = 8'h13; ram[16'h0011] = 8'h05;
        ram[16'h0012] = 8'h50; ram[16'h0013] = 8'h00;
        ram[16'h0014] = 8'h11; ram[16'h0015] = 8'h22;
        ram[16'h0016] = 8'h33; ram[16'h0017] = 8'h44;
        ram[16'hFFFE] = 8'hAA; ram[16'hFFFF] = 8'hBB;
        ram[16'h0000] = 8'hCC; ram[16'h0001] = 8'hDD;

        // reset state
        #12;
        check("rst_busy",  32'(busy),       32'h0);
        check("rst_rden",  32'(mem_rden),   32'h0);
        check("rst_instr", instr[0],        32'h0);
        check("rst_addr",  32'(mem_addr[0]), 32'h0);
        check("rst_wren",  32'(mem_wren),   32'h0);
        @(posedge clk); #1;
        rst = 1'b0; clr_log = 1'b1;
        @(posedge clk); #1;
        clr_log = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("idle_rd", 32'(rd_cnt[0] + rd_cnt[1] + rd_cnt[2]), 32'h0);

        // basic fetch on all three latencies
        launch(3'b111, 32'h0000_0010);
        repeat (24) @(posedge clk);
        #1;
        check("basic_vcyc_l2", 32'(v_cyc[0]), 32'd13);
        check("basic_vcyc_l1", 32'(v_cyc[1]), 32'd9);
        check("basic_vcyc_l4", 32'(v_cyc[2]), 32'd21);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("basic_instr%0d", g), instr[g], 32'h0050_0513);
            check($sformatf("basic_vcnt%0d", g), 32'(v_cnt[g]), 32'd1);
            check($sformatf("basic_rdcnt%0d", g), 32'(rd_cnt[g]), 32'd4);
        end
        for (int k = 0; k < 4; k++)
            check($sformatf("basic_addr%0d", k), 32'(addr_log[0][k]), 32'h10 + 32'(k));
        check("basic_busy", 32'(busy), 32'h0);
        exp_instr = 32'h0050_0513;

        // flush in the WAIT of byte 2: bytes 0,1 captured, byte 2 not
        launch(3'b001, 32'h0000_0014);
        repeat (7) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy[0]), 32'h0);
        repeat (20) @(posedge clk);
        #1;
        check("flush_vcnt",  32'(v_cnt[0]),  32'd0);
        check("flush_rdcnt", 32'(rd_cnt[0]), 32'd3);
        check("flush_instr", instr[0],       32'h0050_2211);

        // start while busy is ignored
        launch(3'b001, 32'h0000_0010);
        repeat (3) @(posedge clk);
        #1 begin start = 3'b001; pc_in = 32'h14; end
        @(posedge clk); #1;
        start = '0;
        repeat (20) @(posedge clk);
        #1;
        check("busy_vcnt",  32'(v_cnt[0]),       32'd1);
        check("busy_vcyc",  32'(v_cyc[0]),       32'd13);
        check("busy_rdcnt", 32'(rd_cnt[0]),      32'd4);
        check("busy_addr3", 32'(addr_log[0][3]), 32'h13);
        check("busy_instr", instr[0],            32'h0050_0513);

        // start and flush together in IDLE
        @(posedge clk); #1;
        clr_log = 1'b1; start = 3'b001; flush = 1'b1; pc_in = 32'h10;
        @(posedge clk); #1;
        clr_log = 1'b0; start = '0; flush = 1'b0;
        check("sf_busy", 32'(busy[0]), 32'h0);
        repeat (10) @(posedge clk);
        #1;
        check("sf_rdcnt", 32'(rd_cnt[0]), 32'd0);
        check("sf_ecnt",  32'(e_cnt[0]),  32'd0);

        // pc beyond the RAM address range
        launch(3'b001, 32'h0001_0000);
        repeat (10) @(posedge clk);
        #1;
        check("oor_ecnt",  32'(e_cnt[0]),  32'd1);
        check("oor_ecyc",  32'(e_cyc[0]),  32'd1);
        check("oor_rdcnt", 32'(rd_cnt[0]), 32'd0);
        check("oor_vcnt",  32'(v_cnt[0]),  32'd0);
        check("oor_instr", instr[0],       exp_instr);

        // address wrap at the top of RAM
        launch(3'b001, 32'h0000_FFFE);
        repeat (20) @(posedge clk);
        #1;
`ifdef FETCH_ALIGN_CHECK_EN
        check("wrap_ecnt",  32'(e_cnt[0]),  32'd1);
        check("wrap_rdcnt", 32'(rd_cnt[0]), 32'd0);
`else
        check("wrap_rdcnt", 32'(rd_cnt[0]),      32'd4);
        check("wrap_addr0", 32'(addr_log[0][0]), 32'hFFFE);
        check("wrap_addr1", 32'(addr_log[0][1]), 32'hFFFF);
        check("wrap_addr2", 32'(addr_log[0][2]), 32'h0000);
        check("wrap_addr3", 32'(addr_log[0][3]), 32'h0001);
        exp_instr = 32'hDDCC_BBAA;
`endif
        check("wrap_instr", instr[0], exp_instr);

        // unaligned pc
        launch(3'b001, 32'h0000_0012);
        repeat (20) @(posedge clk);
        #1;
`ifdef FETCH_ALIGN_CHECK_EN
        check("unal_ecnt",  32'(e_cnt[0]),  32'd1);
        check("unal_ecyc",  32'(e_cyc[0]),  32'd1);
        check("unal_rdcnt", 32'(rd_cnt[0]), 32'd0);
`else
        check("unal_vcnt",  32'(v_cnt[0]),  32'd1);
        check("unal_rdcnt", 32'(rd_cnt[0]), 32'd4);
        exp_instr = 32'h2211_0050;
`endif
        check("unal_instr", instr[0], exp_instr);

        // aligned pc
        launch(3'b001, 32'h0000_0014);
        repeat (20) @(posedge clk);
        #1;
        check("al_vcnt",  32'(v_cnt[0]), 32'd1);
        check("al_vcyc",  32'(v_cyc[0]), 32'd13);
        check("al_ecnt",  32'(e_cnt[0]), 32'd0);
        check("al_instr", instr[0],      32'h4433_2211);

        // asynchronous reset mid-fetch
        launch(3'b111, 32'h0000_0010);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mrst_busy",  32'(busy),        32'h0);
        check("mrst_rden",  32'(mem_rden),    32'h0);
        check("mrst_instr", instr[0],         32'h0);
        check("mrst_addr",  32'(mem_addr[0]), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("mrst_vcnt", 32'(v_cnt[0] + v_cnt[1] + v_cnt[2]), 32'd0);
        check("mrst_ecnt", 32'(e_cnt[0] + e_cnt[1] + e_cnt[2]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Multi-cycle instruction fetcher that assembles one INSTR_W-bit instruction from a narrow, fixed-latency synchronous system RAM.
- Issues BYTES = INSTR_W/DATA_W sequential reads and packs the results little-endian.
- Sits between the processor control FSM (FETCH phase) and system_ram. Replaces the hard-coded wait-count phase with a latency-parametrised, handshaked fetch.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 8, RAM word width; INSTR_W must be a multiple of DATA_W.
- INSTR_W, 32, instruction width.
- PC_W, 32, program counter width.
- RAM_LATENCY, 2, cycles from mem_rden high to valid mem_q. Must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  fetch request; sampled only in IDLE.
- flush  in  1  abort the current fetch; return to IDLE.
- pc_in  in  PC_W  byte address of the instruction; latched on an accepted start.
- busy  out  1  high in every state except IDLE.
- instr_valid  out  1  one-cycle pulse; instr is complete.
- instr  out  INSTR_W  assembled instruction; held until the next accepted start.
- fetch_err  out  1  one-cycle pulse on a rejected fetch.
- mem_rden  out  1  RAM read enable.
- mem_wren  out  1  tied 0; this block never writes.
- mem_addr  out  ADDR_W  RAM address.
- mem_q  in  DATA_W  RAM read data.

Behaviour:
- Reset (async, rst=1): state=IDLE. busy, instr_valid, fetch_err and mem_rden are 0. instr=0, mem_addr=0, byte index=0, latency counter=0.
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE:
  - start=1 with flush=0: latch base=pc_in[ADDR_W-1:0], idx=0, go to ISSUE.
  - A pc_in with nonzero bits above ADDR_W-1 goes to ERR instead.
  - flush=1 wins over start.
- ISSUE (1 cycle): mem_rden=1, mem_addr=base+idx (mod 2^ADDR_W; wraps 0xFFFF→0x0000). Clear cnt, go to WAIT.
- WAIT: mem_rden=0; cnt increments each cycle.
  - When cnt==RAM_LATENCY-1, capture mem_q into instr[idx*DATA_W +: DATA_W].
  - Then: if idx==BYTES-1 go to DONE, else idx++ and go to ISSUE.
- DONE (1 cycle): instr_valid=1, then IDLE. A start in DONE is ignored; the requester waits for busy=0.
- ERR (1 cycle): fetch_err=1, no RAM access, instr unchanged, then IDLE.
- Latency: start sampled at cycle 0 → instr_valid in cycle 1+BYTES*(1+RAM_LATENCY). Defaults give cycle 13.
- flush in ISSUE, WAIT or DONE: next state is IDLE. No instr_valid; partially captured bytes remain in instr but are not flagged valid.
- start while busy: ignored, not queued.
- rst mid-fetch: immediate return to reset values. No pulse is emitted.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined: a start with pc_in[log2(BYTES)-1:0]≠0 goes to ERR (fetch_err pulse, no mem_rden).
- Undefined: any byte address is fetched. Reads are sequential from the unaligned base, with address wrap as above.

Decomposition:
- Package fetch_pkg holds:
  - state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3, ERR=4)
  - the BYTES function/constant
  - the IDX_W=$clog2(BYTES) and CNT_W=$clog2(RAM_LATENCY+1) localparams
- One sub-module is natural: fetch_latency_counter (load/clear, increment, terminal-count flag at RAM_LATENCY-1).
- Byte packing stays in the top module.

Test Plan:
- Reset/idle: assert rst mid-run → busy=0, instr=0, mem_rden=0, state IDLE. Release, no start → no RAM activity for 20 cycles.
- Basic fetch: RAM bytes 0x13,0x05,0x50,0x00 at 0x0010; start with pc_in=0x10 → mem_addr sequence 0x10,0x11,0x12,0x13; instr_valid at cycle 13; instr=0x00500513.
- Latency sweep: RAM_LATENCY=1 and 4 → instr_valid at cycles 9 and 21; same instr value.
- Wrap: FETCH_ALIGN_CHECK_EN undefined, pc_in=0xFFFE → addresses 0xFFFE,0xFFFF,0x0000,0x0001. pc_in=0x0001_0000 → fetch_err pulse, no mem_rden.
- Alignment: FETCH_ALIGN_CHECK_EN defined, pc_in=0x0012 → fetch_err at cycle 1, instr unchanged. pc_in=0x0014 → normal fetch.
- Flush/contention: flush in the WAIT of byte 2 → IDLE next cycle, no instr_valid. start during busy is ignored. start+flush in IDLE → stays IDLE.
